// File: rtl/adma_pkg.sv
// Shared descriptor type and 1D-mode defaults for the ADMA descriptor queue.
package adma_pkg;

    localparam int ADMA_SRC_ADDR_W = 32;
    localparam int ADMA_DST_ADDR_W = 32;
    localparam int ADMA_LENGTH_W   = 16;

    typedef struct packed {
        logic [ADMA_SRC_ADDR_W-1:0] src_addr;
        logic [ADMA_DST_ADDR_W-1:0] dst_addr;
        logic [ADMA_LENGTH_W-1:0]   xlen;
        logic [ADMA_LENGTH_W-1:0]   ylen;
        logic [ADMA_LENGTH_W-1:0]   src_strd;
        logic [ADMA_LENGTH_W-1:0]   dst_strd;
    } adma_desc_t;

    localparam logic [ADMA_LENGTH_W-1:0] ADMA_1D_YLEN = ADMA_LENGTH_W'(1);
    localparam logic [ADMA_LENGTH_W-1:0] ADMA_1D_STRD = '0;

    // A 1D transfer is one row with no stride, whatever the CSRs held.
    function automatic adma_desc_t adma_apply_mode(input adma_desc_t d, input logic xfer_2d);
        adma_desc_t r;
        r = d;
        if (!xfer_2d) begin
            r.ylen     = ADMA_1D_YLEN;
            r.src_strd = ADMA_1D_STRD;
            r.dst_strd = ADMA_1D_STRD;
        end
        return r;
    endfunction

endpackage

// File: rtl/adma_desc_queue_if.sv
// Push (CSR side) and issue (engine side) handshakes of one ADMA descriptor queue.
interface adma_desc_queue_if #(
    parameter int DMA_DESC_DEPTH = 4,
    parameter int SRC_ADDR_W     = 32,
    parameter int DST_ADDR_W     = 32,
    parameter int DMA_LENGTH_W   = 16
);
    localparam int DMA_XFER_ID_W = $clog2(DMA_DESC_DEPTH);

    logic                     desc_wr_vld_i;
    logic                     desc_wr_rdy_o;
    logic [SRC_ADDR_W-1:0]    desc_src_addr_i;
    logic [DST_ADDR_W-1:0]    desc_dst_addr_i;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_xlen_i;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_ylen_i;
    logic [DMA_LENGTH_W-1:0]  desc_src_strd_i;
    logic [DMA_LENGTH_W-1:0]  desc_dst_strd_i;

    logic                     iss_vld_o;
    logic                     iss_rdy_i;
    logic [DMA_XFER_ID_W-1:0] iss_id_o;
    logic [SRC_ADDR_W-1:0]    iss_src_addr_o;
    logic [DST_ADDR_W-1:0]    iss_dst_addr_o;
    logic [DMA_LENGTH_W-1:0]  iss_xlen_o;
    logic [DMA_LENGTH_W-1:0]  iss_ylen_o;
    logic [DMA_LENGTH_W-1:0]  iss_src_strd_o;
    logic [DMA_LENGTH_W-1:0]  iss_dst_strd_o;

    modport slave (
        input  desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xfer_xlen_i,
               desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i, iss_rdy_i,
        output desc_wr_rdy_o, iss_vld_o, iss_id_o, iss_src_addr_o, iss_dst_addr_o,
               iss_xlen_o, iss_ylen_o, iss_src_strd_o, iss_dst_strd_o
    );

    modport master (
        output desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xfer_xlen_i,
               desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i, iss_rdy_i,
        input  desc_wr_rdy_o, iss_vld_o, iss_id_o, iss_src_addr_o, iss_dst_addr_o,
               iss_xlen_o, iss_ylen_o, iss_src_strd_o, iss_dst_strd_o
    );
endinterface

// File: rtl/adma_desc_ram.sv
// Descriptor storage: one write port, two asynchronous read ports (issue, cyclic copy).
module adma_desc_ram
    import adma_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       we,
    input  logic [AW-1:0] waddr,
    input  adma_desc_t wdata,
    input  logic [AW-1:0] raddr_a,
    output adma_desc_t rdata_a,
    input  logic [AW-1:0] raddr_b,
    output adma_desc_t rdata_b
);
    adma_desc_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/adma_desc_queue.sv
// Per-channel ADMA descriptor queue: push from CSRs, in-order issue, completion tracking.
// Optional ADMA_DESC_CYCLIC_EN: completed descriptors re-append themselves when xfer_cyclic_i=1.
module adma_desc_queue
    import adma_pkg::*;
#(
    parameter  int DMA_DESC_DEPTH = 4,
    parameter  int SRC_ADDR_W     = 32,
    parameter  int DST_ADDR_W     = 32,
    parameter  int DMA_LENGTH_W   = 16,
    localparam int DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      chn_en_i,
    input  logic                      xfer_2d_i,
    input  logic                      xfer_cyclic_i,
    input  logic                      xfer_cmpl_i,
    adma_desc_queue_if.slave          q_if,
    output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
    output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
    output logic                      irq_qed_o,
    output logic                      irq_com_o
);
    localparam int ID_W  = DMA_XFER_ID_W;
    localparam int PTR_W = ID_W + 1;

    logic [PTR_W-1:0]          wr_ptr, iss_ptr, cmp_ptr, count;
    logic [ID_W-1:0]           wr_slot, iss_slot, cmp_slot;
    logic                      full, push, iss_fire, cmpl_ok, reappend, cyc_block, we;
    logic [DMA_DESC_DEPTH-1:0] done_nxt;
    adma_desc_t                new_desc, iss_desc, cyc_desc, wr_desc;

    assign wr_slot  = wr_ptr[ID_W-1:0];
    assign iss_slot = iss_ptr[ID_W-1:0];
    assign cmp_slot = cmp_ptr[ID_W-1:0];
    assign count    = wr_ptr - cmp_ptr;
    assign full     = (count == PTR_W'(DMA_DESC_DEPTH));

`ifdef ADMA_DESC_CYCLIC_EN
    // The write port is needed for the re-append, so pushes yield to it.
    assign cyc_block = xfer_cmpl_i & xfer_cyclic_i;
    assign reappend  = cmpl_ok & xfer_cyclic_i;
`else
    logic unused_cyclic;
    assign unused_cyclic = xfer_cyclic_i;
    assign cyc_block     = 1'b0;
    assign reappend      = 1'b0;
`endif

    assign q_if.desc_wr_rdy_o = chn_en_i & ~full & ~cyc_block;
    assign push               = q_if.desc_wr_vld_i & q_if.desc_wr_rdy_o;
    assign q_if.iss_vld_o     = chn_en_i & (iss_ptr != wr_ptr);
    assign iss_fire           = q_if.iss_vld_o & q_if.iss_rdy_i;
    assign cmpl_ok            = xfer_cmpl_i & (cmp_ptr != iss_ptr);

    always_comb begin
        new_desc          = '0;
        new_desc.src_addr = ADMA_SRC_ADDR_W'(q_if.desc_src_addr_i);
        new_desc.dst_addr = ADMA_DST_ADDR_W'(q_if.desc_dst_addr_i);
        new_desc.xlen     = ADMA_LENGTH_W'(q_if.desc_xfer_xlen_i);
        new_desc.ylen     = ADMA_LENGTH_W'(q_if.desc_xfer_ylen_i);
        new_desc.src_strd = ADMA_LENGTH_W'(q_if.desc_src_strd_i);
        new_desc.dst_strd = ADMA_LENGTH_W'(q_if.desc_dst_strd_i);
        new_desc          = adma_apply_mode(new_desc, xfer_2d_i);
    end

    assign we      = push | reappend;
    assign wr_desc = push ? new_desc : cyc_desc;

    adma_desc_ram #(.DEPTH(DMA_DESC_DEPTH)) u_ram (
        .clk     (aclk),
        .we      (we),
        .waddr   (wr_slot),
        .wdata   (wr_desc),
        .raddr_a (iss_slot),
        .rdata_a (iss_desc),
        .raddr_b (cmp_slot),
        .rdata_b (cyc_desc)
    );

    assign q_if.iss_id_o       = iss_slot;
    assign q_if.iss_src_addr_o = SRC_ADDR_W'(iss_desc.src_addr);
    assign q_if.iss_dst_addr_o = DST_ADDR_W'(iss_desc.dst_addr);
    assign q_if.iss_xlen_o     = DMA_LENGTH_W'(iss_desc.xlen);
    assign q_if.iss_ylen_o     = DMA_LENGTH_W'(iss_desc.ylen);
    assign q_if.iss_src_strd_o = DMA_LENGTH_W'(iss_desc.src_strd);
    assign q_if.iss_dst_strd_o = DMA_LENGTH_W'(iss_desc.dst_strd);

    // Set before clear: a re-append into the slot just completed leaves it pending.
    always_comb begin
        done_nxt = xfer_done_o;
        if (cmpl_ok) done_nxt[cmp_slot] = 1'b1;
        if (we)      done_nxt[wr_slot]  = 1'b0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            iss_ptr     <= '0;
            cmp_ptr     <= '0;
            xfer_done_o <= '1;
            irq_qed_o   <= 1'b0;
            irq_com_o   <= 1'b0;
        end else begin
            if (we)       wr_ptr  <= wr_ptr + 1'b1;
            if (iss_fire) iss_ptr <= iss_ptr + 1'b1;
            if (cmpl_ok)  cmp_ptr <= cmp_ptr + 1'b1;
            xfer_done_o <= done_nxt;
            irq_qed_o   <= push;
            irq_com_o   <= cmpl_ok;
        end
    end

    assign xfer_id_o        = wr_slot;
    assign active_xfer_id_o = cmp_slot;
endmodule

// File: tb/tb_adma_desc_queue.sv
// Scoreboard bench for adma_desc_queue: expected issues queued on push, checked on issue.
module tb_adma_desc_queue;
    import adma_pkg::*;

    localparam int D = 4;
`ifdef ADMA_DESC_CYCLIC_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         en, x2d, cyc, cmpl;
    logic [1:0]   xfer_id, active;
    logic [D-1:0] done;
    logic         irq_qed, irq_com;

    always #5 aclk = ~aclk;

    adma_desc_queue_if #(.DMA_DESC_DEPTH(D)) q_if ();

    adma_desc_queue #(.DMA_DESC_DEPTH(D)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .chn_en_i         (en),
        .xfer_2d_i        (x2d),
        .xfer_cyclic_i    (cyc),
        .xfer_cmpl_i      (cmpl),
        .q_if             (q_if),
        .xfer_id_o        (xfer_id),
        .xfer_done_o      (done),
        .active_xfer_id_o (active),
        .irq_qed_o        (irq_qed),
        .irq_com_o        (irq_com)
    );

    typedef struct {
        int          id;
        logic [31:0] src, dst;
        logic [15:0] xl, yl, ss, ds;
    } exp_t;

    exp_t         sb[$];
    exp_t         m_mem[D];
    int           m_wr, m_iss, m_cmp;
    logic [D-1:0] m_done;
    int           n_chk, n_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] xl,
                              input logic [15:0] yl, input logic [15:0] ss, input logic [15:0] ds);
        q_if.desc_wr_vld_i    = 1'b1;
        q_if.desc_src_addr_i  = s;
        q_if.desc_dst_addr_i  = d;
        q_if.desc_xfer_xlen_i = xl;
        q_if.desc_xfer_ylen_i = yl;
        q_if.desc_src_strd_i  = ss;
        q_if.desc_dst_strd_i  = ds;
    endtask

    // One clock: inputs are already driven (just after a negedge); ends on the next negedge.
    task automatic cycle();
        exp_t e, cp;
        bit   exp_rdy, exp_vld, push, iss, cok, reap;
        #1;
        exp_rdy = en && ((m_wr - m_cmp) < D) && !(CYC && cmpl && cyc);
        exp_vld = en && (m_iss != m_wr);
        chk("desc_wr_rdy", q_if.desc_wr_rdy_o, exp_rdy);
        chk("iss_vld", q_if.iss_vld_o, exp_vld);
        if (exp_vld) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                e = sb[0];
                chk("iss_id", q_if.iss_id_o, e.id);
                chk("iss_src", q_if.iss_src_addr_o, e.src);
                chk("iss_dst", q_if.iss_dst_addr_o, e.dst);
                chk("iss_xlen", q_if.iss_xlen_o, e.xl);
                chk("iss_ylen", q_if.iss_ylen_o, e.yl);
                chk("iss_src_strd", q_if.iss_src_strd_o, e.ss);
                chk("iss_dst_strd", q_if.iss_dst_strd_o, e.ds);
            end
        end
        push = q_if.desc_wr_vld_i && exp_rdy;
        iss  = exp_vld && q_if.iss_rdy_i;
        cok  = cmpl && (m_cmp != m_iss);
        reap = CYC && cok && cyc;
        if (iss && sb.size() > 0) e = sb.pop_front();
        if (cok) begin
            m_done[m_cmp % D] = 1'b1;
            if (reap) begin
                cp    = m_mem[m_cmp % D];
                cp.id = m_wr % D;
                m_mem[m_wr % D] = cp;
                sb.push_back(cp);
                m_done[m_wr % D] = 1'b0;
                m_wr++;
            end
            m_cmp++;
        end
        if (push) begin
            e.id  = m_wr % D;
            e.src = q_if.desc_src_addr_i;
            e.dst = q_if.desc_dst_addr_i;
            e.xl  = q_if.desc_xfer_xlen_i;
            e.yl  = x2d ? q_if.desc_xfer_ylen_i : 16'd1;
            e.ss  = x2d ? q_if.desc_src_strd_i : 16'd0;
            e.ds  = x2d ? q_if.desc_dst_strd_i : 16'd0;
            m_mem[m_wr % D] = e;
            sb.push_back(e);
            m_done[m_wr % D] = 1'b0;
            m_wr++;
        end
        if (iss) m_iss++;
        @(posedge aclk);
        #1;
        chk("irq_qed", irq_qed, push);
        chk("irq_com", irq_com, cok);
        chk("xfer_id", xfer_id, m_wr % D);
        chk("active_id", active, m_cmp % D);
        chk("done_map", done, m_done);
        @(negedge aclk);
    endtask

    task automatic drain();
        en = 1'b1; cyc = 1'b0; cmpl = 1'b1;
        q_if.desc_wr_vld_i = 1'b0;
        q_if.iss_rdy_i     = 1'b1;
        for (int i = 0; i < 40 && m_cmp != m_wr; i++) cycle();
        chk("drained_active", active, m_wr % D);
        cmpl = 1'b0;
        q_if.iss_rdy_i = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_wr = 0; m_iss = 0; m_cmp = 0; m_done = '1;
        aresetn = 1'b0; en = 1'b0; x2d = 1'b1; cyc = 1'b0; cmpl = 1'b0;
        q_if.iss_rdy_i = 1'b0;
        drive_desc(32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        q_if.desc_wr_vld_i = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rdy", q_if.desc_wr_rdy_o, 1'b0);
        chk("rst_iss_vld", q_if.iss_vld_o, 1'b0);
        chk("rst_done", done, {D{1'b1}});
        chk("rst_irq", {irq_qed, irq_com}, 2'b00);
        chk("rst_ids", {xfer_id, active}, 4'h0);
        aresetn = 1'b1;
        cycle();

        // First push, then watch it become visible to the engine.
        en = 1'b1;
        drive_desc(32'h1000, 32'h2000, 16'd64, 16'd1, 16'd0, 16'd0);
        cycle();
        q_if.desc_wr_vld_i = 1'b0;
        cycle();

        // Fill to full with the engine stalled, then push while a completion lands.
        for (int i = 1; i < 4; i++) begin
            drive_desc($urandom, $urandom, 16'(i * 3), 16'(i), 16'(i + 8), 16'(i + 9));
            cycle();
        end
        cycle();
        q_if.desc_wr_vld_i = 1'b0;
        q_if.iss_rdy_i = 1'b1;
        cycle();
        q_if.iss_rdy_i = 1'b0;
        drive_desc(32'hA5A5_0000, 32'h5A5A_0000, 16'd7, 16'd3, 16'd5, 16'd6);
        cmpl = 1'b1;
        cycle();
        cmpl = 1'b0;
        cycle();
        q_if.desc_wr_vld_i = 1'b0;
        drain();

        // 1D mode overrides ylen and strides; then a spurious completion.
        x2d = 1'b0;
        drive_desc(32'h3000, 32'h4000, 16'd32, 16'd8, 16'd16, 16'd16);
        cycle();
        q_if.desc_wr_vld_i = 1'b0;
        x2d = 1'b1;
        cycle();
        cmpl = 1'b1;
        cycle();
        cmpl = 1'b0;
        q_if.iss_rdy_i = 1'b1;
        cycle();
        q_if.iss_rdy_i = 1'b0;
        cmpl = 1'b1;
        cycle();
        cmpl = 1'b0;
        cycle();

        // Six push/issue/complete rounds: IDs wrap around the slots.
        for (int i = 0; i < 6; i++) begin
            drive_desc(32'h100 * i, 32'h200 * i, 16'(i + 1), 16'(2 * i), 16'(i), 16'(i + 4));
            cycle();
            q_if.desc_wr_vld_i = 1'b0;
            q_if.iss_rdy_i = 1'b1;
            cycle();
            q_if.iss_rdy_i = 1'b0;
            cmpl = 1'b1;
            cycle();
            cmpl = 1'b0;
        end

        // Channel disabled: nothing pushed or issued, issued work still completes.
        drive_desc(32'h7000, 32'h8000, 16'd9, 16'd2, 16'd1, 16'd1);
        cycle();
        q_if.iss_rdy_i = 1'b1;
        cycle();
        en = 1'b0;
        cmpl = 1'b1;
        drive_desc(32'h7100, 32'h8100, 16'd9, 16'd2, 16'd1, 16'd1);
        cycle();
        cycle();
        en = 1'b1;
        cmpl = 1'b0;
        q_if.desc_wr_vld_i = 1'b0;
        drain();

        // Cyclic single descriptor.
        cyc = 1'b1;
        drive_desc(32'hC000, 32'hD000, 16'd48, 16'd4, 16'd2, 16'd3);
        cycle();
        q_if.desc_wr_vld_i = 1'b0;
        q_if.iss_rdy_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cmpl = 1'(i % 2);
            cycle();
        end
        drain();

        // Random mix of everything.
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            x2d  = 1'($urandom);
            cyc  = 1'($urandom);
            cmpl = 1'($urandom);
            q_if.iss_rdy_i = 1'($urandom);
            if ($urandom_range(0, 1) != 0)
                drive_desc($urandom, $urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            else
                q_if.desc_wr_vld_i = 1'b0;
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
